// File: rtl/fwd_mux_reg.sv
// Registered N-input operand forwarding selector with stall, flush and valid tracking.
// Define FWD_MUX_STATS_EN to add saturating per-input select counters (StatClr/HitCnt).
module fwd_mux_reg #(
    parameter int DWL    = 32,
    parameter int NUM_IN = 3,
    parameter int SWL    = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    En,
    input  logic                    Flush,
    input  logic                    InValid,
    input  logic [NUM_IN*DWL-1:0]   In,
    input  logic [SWL-1:0]          Sel,
    output logic [DWL-1:0]          Out,
    output logic                    OutValid,
    output logic                    SelErr
`ifdef FWD_MUX_STATS_EN
    ,
    input  logic                    StatClr,
    output logic [NUM_IN*CNT_W-1:0] HitCnt
`endif
);

    generate
        if (NUM_IN < 2 || NUM_IN > 16 || SWL < $clog2(NUM_IN) || CNT_W < 1) begin : g_param_check
            $error("fwd_mux_reg: illegal parameters (NUM_IN must be 2..16, SWL >= clog2(NUM_IN), CNT_W >= 1)");
        end
    endgenerate

    logic [DWL-1:0] out_q, out_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           sel_legal;
    logic [DWL-1:0] sel_word;

    // Out-of-range selects fall through to a zero word; sel_legal keeps it from reaching Out.
    always_comb begin
        sel_legal = (int'(Sel) < NUM_IN);
        sel_word  = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(Sel) == k) begin
                sel_word = In[k*DWL +: DWL];
            end
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (Flush) begin
            out_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (En) begin
            if (sel_legal) begin
                out_d   = sel_word;
                valid_d = InValid;
                err_d   = 1'b0;
            end else begin
                valid_d = 1'b0;
                err_d   = InValid;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign Out      = out_q;
    assign OutValid = valid_q;
    assign SelErr   = err_q;

`ifdef FWD_MUX_STATS_EN
    logic [CNT_W-1:0] hit_q [NUM_IN];
    logic [CNT_W-1:0] hit_d [NUM_IN];
    logic             accept;

    assign accept = !Flush && En && InValid && sel_legal;

    // Counters saturate at all-ones; a clear wins over a same-edge increment.
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            hit_d[k] = hit_q[k];
            if (StatClr) begin
                hit_d[k] = '0;
            end else if (accept && int'(Sel) == k && hit_q[k] != {CNT_W{1'b1}}) begin
                hit_d[k] = hit_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (RST) begin
                hit_q[k] <= '0;
            end else begin
                hit_q[k] <= hit_d[k];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_hit_out
            assign HitCnt[g*CNT_W +: CNT_W] = hit_q[g];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Directed self-checking bench for fwd_mux_reg (NUM_IN=3, DWL=32, SWL=2, CNT_W=2).
module tb_fwd_mux_reg;

    localparam int DWL    = 32;
    localparam int NUM_IN = 3;
    localparam int SWL    = 2;
    localparam int CNT_W  = 2;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  En;
    logic                  Flush;
    logic                  InValid;
    logic [NUM_IN*DWL-1:0] In;
    logic [SWL-1:0]        Sel;
    logic [DWL-1:0]        Out;
    logic                  OutValid;
    logic                  SelErr;
`ifdef FWD_MUX_STATS_EN
    logic                    StatClr;
    logic [NUM_IN*CNT_W-1:0] HitCnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    fwd_mux_reg #(
        .DWL(DWL), .NUM_IN(NUM_IN), .SWL(SWL), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .En(En),
        .Flush(Flush),
        .InValid(InValid),
        .In(In),
        .Sel(Sel),
        .Out(Out),
        .OutValid(OutValid),
        .SelErr(SelErr)
`ifdef FWD_MUX_STATS_EN
        ,
        .StatClr(StatClr),
        .HitCnt(HitCnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's controls, then settle just past the next rising edge.
    task automatic applyStimulus(input logic en, input logic flush, input logic inValid, input logic [SWL-1:0] sel);
        En      = en;
        Flush   = flush;
        InValid = inValid;
        Sel     = sel;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [DWL-1:0] expOut, input logic expValid, input logic expErr);
        checkOutput({tag, ".Out"}, 64'(Out), 64'(expOut));
        checkOutput({tag, ".OutValid"}, 64'(OutValid), 64'(expValid));
        checkOutput({tag, ".SelErr"}, 64'(SelErr), 64'(expErr));
    endtask

    initial begin
        RST = 1'b1;
        En = 1'b1; Flush = 1'b0; InValid = 1'b1; Sel = 2'd1;
        In = {32'h33, 32'h22, 32'h11};
`ifdef FWD_MUX_STATS_EN
        StatClr = 1'b0;
`endif

        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        checkState("reset", 32'h0, 1'b0, 1'b0);

        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        checkState("first_sel1", 32'h22, 1'b1, 1'b0);

        Sel = 2'd0;
        #1;
        checkOutput("no_comb_path", 64'(Out), 64'h22);

        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
        checkState("sweep0", 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        checkState("sweep1", 32'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
        checkState("sweep2", 32'h33, 1'b1, 1'b0);

        In[0 +: DWL] = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
            checkState("stall_hold", 32'h33, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
        checkState("stall_release", 32'hAA, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1);
        checkState("invalid_data", 32'h22, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2);
        checkState("flush", 32'h0, 1'b0, 1'b0);

        In[0 +: DWL] = 32'h11;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        checkState("pre_illegal", 32'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
        checkState("illegal_sel", 32'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0);
        checkState("err_clears", 32'h11, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd3);
        checkState("illegal_invalid", 32'h11, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
        checkState("err_again", 32'h11, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        checkState("err_stall_hold", 32'h11, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0);
        checkState("flush_over_stall", 32'h0, 1'b0, 1'b0);

        RST = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
        RST = 1'b0;
        checkState("reset_over_en", 32'h0, 1'b0, 1'b0);

`ifdef FWD_MUX_STATS_EN
        StatClr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
        StatClr = 1'b0;
        checkOutput("stat_clear_all", 64'(HitCnt), 64'h0);

        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        checkOutput("hit1_two", 64'(HitCnt[1*CNT_W +: CNT_W]), 64'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        end
        checkOutput("hit1_saturated", 64'(HitCnt[1*CNT_W +: CNT_W]), 64'd3);
        checkOutput("hit0_zero", 64'(HitCnt[0 +: CNT_W]), 64'd0);
        checkOutput("hit2_zero", 64'(HitCnt[2*CNT_W +: CNT_W]), 64'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0);
        checkOutput("stall_no_count", 64'(HitCnt[0 +: CNT_W]), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2);
        checkOutput("flush_no_count", 64'(HitCnt[2*CNT_W +: CNT_W]), 64'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3);
        checkOutput("illegal_no_count", 64'(HitCnt), 64'(6'b00_11_00));
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2);
        checkOutput("hit2_one", 64'(HitCnt[2*CNT_W +: CNT_W]), 64'd1);

        StatClr = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1);
        StatClr = 1'b0;
        checkOutput("clr_beats_inc", 64'(HitCnt[1*CNT_W +: CNT_W]), 64'd0);
        checkOutput("clr_all", 64'(HitCnt), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fwd_mux_reg.md
Name: fwd_mux_reg

Overview:
- Parametrised N-input operand forwarding selector with a registered output stage, for the pipelined datapath's EX-stage operand paths.
- Generalises the fixed 3-way combinational forwarding mux:
  - any input count and data width;
  - defined out-of-range select behaviour, so no inferred latch;
  - pipeline stall and flush control, and a valid bit.
- Optionally keeps saturating per-input select counters for forwarding-rate profiling.

Parameters:
- DWL, 32, data word width in bits.
- NUM_IN, 3, number of selectable inputs; legal range 2..16.
- SWL, 2, select width; must be at least clog2(NUM_IN).
- CNT_W, 16, width of each per-input statistics counter; used only with the optional feature.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- En  input  1  stage enable; 0 means stall, and all state holds.
- Flush  input  1  bubble insert; has priority over En.
- InValid  input  1  the current In/Sel pair is a real instruction's operand request.
- In  input  NUM_IN*DWL  packed data inputs; input k occupies bits [k*DWL +: DWL].
- Sel  input  SWL  binary index of the input to forward.
- Out  output  DWL  registered selected word.
- OutValid  output  1  Out holds a valid operand.
- SelErr  output  1  registered flag: the last accepted valid request had an illegal Sel.
- StatClr  input  1  present only with FWD_MUX_STATS_EN; synchronous counter clear.
- HitCnt  output  NUM_IN*CNT_W  present only with FWD_MUX_STATS_EN; counter k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Latency: exactly 1 CLK from In/Sel sampled to Out, with no combinational path from In to Out.
- Reset (RST=1 at an edge): Out=0, OutValid=0, SelErr=0, all HitCnt=0. RST overrides Flush, En and StatClr.
- Priority at each edge, highest first: RST > Flush > En.
- Flush=1:
  - OutValid<=0, SelErr<=0, Out<=0.
  - Counters do not increment.
- Flush=0, En=0 (stall):
  - Out, OutValid, SelErr and counters all hold.
  - Inputs are ignored.
- Flush=0, En=1, legal Sel (Sel<NUM_IN):
  - Out<=In[Sel], OutValid<=InValid, SelErr<=0.
- Flush=0, En=1, illegal Sel (Sel>=NUM_IN):
  - Out holds its previous value and OutValid<=0.
  - SelErr<=InValid.
  - The error does not persist; it is recomputed on every enabled edge.
- Data path: Out is still updated when InValid=0 and Sel is legal; consumers qualify Out with OutValid.
- Combinational select logic assigns a default on every path, so no latch is inferred.
- Static check: if SWL<clog2(NUM_IN) or NUM_IN<2, elaboration fails (generate-time error).

Optional Feature:
- Macro: FWD_MUX_STATS_EN.
- Defined:
  - Adds StatClr and HitCnt.
  - On an accepted transfer (En=1, Flush=0, InValid=1, legal Sel), HitCnt[Sel] increments by 1 and saturates at 2^CNT_W-1; there is no wrap.
  - StatClr=1 zeroes all counters at the edge and wins over a same-cycle increment.
  - Stall and flush do not count.
- Undefined:
  - StatClr and HitCnt are absent and no counter flops are built.
  - Out, OutValid and SelErr behaviour is identical to the defined case.

Test Plan:
- Reset then select: RST=1 for 2 cycles, then En=1, InValid=1, In[0]=0x11, In[1]=0x22, In[2]=0x33, Sel=1.
  - Required response: after reset Out=0 and OutValid=0; one edge later Out=0x22, OutValid=1.
- Latency and sweep: Sel=0,1,2 on consecutive cycles.
  - Required response: Out=0x11, 0x22, 0x33 on the following cycles, each exactly 1 cycle late.
- Stall hold: Out=0x33; En=0 for 3 cycles while In[0] changes to 0xAA and Sel=0.
  - Required response: Out stays 0x33 and OutValid stays 1.
  - Raising En then gives Out=0xAA.
- Flush over enable: En=1, Flush=1, InValid=1, Sel=2.
  - Required response: OutValid=0, Out=0, SelErr=0.
- Illegal select: Sel=3 with NUM_IN=3, InValid=1, and prior Out=0x22.
  - Required response: Out stays 0x22, OutValid=0, SelErr=1.
  - Next cycle with Sel=0 clears SelErr and gives Out=0x11.
- Stats (FWD_MUX_STATS_EN, CNT_W=2):
  - 5 accepted transfers with Sel=1: HitCnt[1]=3 (saturated) and the other counters are 0.
  - A stalled cycle adds nothing.
  - StatClr together with an accepted transfer gives HitCnt[1]=0.
